// File: rtl/viterbi_pkg.sv
// Shared constants, FSM state type and trellis helper for the Viterbi traceback slice.
package viterbi_pkg;

  localparam int SW_DEF     = 3;
  localparam int TB_LEN_DEF = 16;
  localparam int MAX_SW     = 8;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    TRACE = 2'd1,
    EMIT  = 2'd2
  } tb_fsm_e;

  // Predecessor of a state along the survivor with MSB d: {d, state[sw-1:1]}.
  function automatic logic [MAX_SW-1:0] prev_state(input logic [MAX_SW-1:0] state,
                                                   input logic d, input int sw);
    logic [MAX_SW-1:0] r;
    r = state >> 1;
    r[sw-1] = d;
    return r;
  endfunction

endpackage

// File: rtl/viterbi_traceback_if.sv
// Step input / decoded-bit output bundle of the traceback stage.
interface viterbi_traceback_if #(
  parameter int SW = 3
);
  localparam int NS = 1 << SW;

  logic          in_valid;
  logic          in_ready;
  logic [NS-1:0] dec_vec;
  logic [SW-1:0] best_state;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic          out_bit;
  logic          out_last;
  logic          busy;

  modport master (
    output in_valid, dec_vec, best_state, flush, out_ready,
    input  in_ready, out_valid, out_bit, out_last, busy
  );

  modport slave (
    input  in_valid, dec_vec, best_state, flush, out_ready,
    output in_ready, out_valid, out_bit, out_last, busy
  );

endinterface

// File: rtl/viterbi_survivor_ram.sv
// TB_LEN x NS survivor memory: synchronous write, asynchronous column read.
module viterbi_survivor_ram #(
  parameter int SW     = 3,
  parameter int TB_LEN = 16,
  localparam int NS    = 1 << SW,
  localparam int AW    = (TB_LEN > 1) ? $clog2(TB_LEN) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [NS-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [NS-1:0] rdata
);

  logic [NS-1:0] mem_r [TB_LEN];

  // Column write on each accepted trellis step.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/viterbi_traceback.sv
// Survivor storage, traceback FSM and chronological bit output of the Viterbi decoder.
// Option: VITERBI_TB_BEST_START_EN starts traceback from the last latched best_state.
module viterbi_traceback
  import viterbi_pkg::*;
#(
  parameter int SW     = SW_DEF,
  parameter int TB_LEN = TB_LEN_DEF
) (
  input logic               clk,
  input logic               reset,
  viterbi_traceback_if.slave bus
);

  localparam int NS = 1 << SW;
  localparam int AW = (TB_LEN > 1) ? $clog2(TB_LEN) : 1;
  localparam int CW = $clog2(TB_LEN + 1);
  localparam logic [CW-1:0] LEN_FULL = CW'(TB_LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(TB_LEN - 1);
  localparam logic [AW-1:0] IDX_LAST = AW'(TB_LEN - 1);

  tb_fsm_e           state_r, state_s;
  logic [CW-1:0]     wr_cnt_r, wr_cnt_s, len_r, len_s, fill_cnt_s;
  logic [AW-1:0]     tb_idx_r, tb_idx_s, out_idx_r, out_idx_s, nxt_idx_s;
  logic [SW-1:0]     tb_state_r, tb_state_s, start_sel_s;
  logic [TB_LEN-1:0] lifo_r, lifo_s;
  logic              out_valid_r, out_valid_s;
  logic              out_bit_r, out_bit_s;
  logic              out_last_r, out_last_s;
  logic              busy_r, in_ready_r;
  logic              accept_s, we_s, d_s;
  logic [NS-1:0]     col_s;

  assign accept_s   = bus.in_valid & in_ready_r;
  assign we_s       = accept_s & ~reset;
  assign fill_cnt_s = wr_cnt_r + CW'(accept_s);

  viterbi_survivor_ram #(
    .SW     (SW),
    .TB_LEN (TB_LEN)
  ) u_ram (
    .clk   (clk),
    .we    (we_s),
    .waddr (wr_cnt_r[AW-1:0]),
    .wdata (bus.dec_vec),
    .raddr (tb_idx_r),
    .rdata (col_s)
  );

  assign d_s = col_s[tb_state_r];

`ifdef VITERBI_TB_BEST_START_EN
  logic [SW-1:0] start_state_r;

  // Best state of the most recent accepted column.
  always_ff @(posedge clk) begin
    if (reset) begin
      start_state_r <= {SW{1'b0}};
    end else if (accept_s) begin
      start_state_r <= bus.best_state;
    end
  end

  // A same-cycle accept is the last column, so its best_state wins.
  assign start_sel_s = accept_s ? bus.best_state : start_state_r;
`else
  logic unused_best_s;
  assign unused_best_s = ^bus.best_state;
  assign start_sel_s   = {SW{1'b0}};
`endif

  // Next-state, traceback step and output loading.
  always_comb begin
    state_s     = state_r;
    wr_cnt_s    = wr_cnt_r;
    len_s       = len_r;
    tb_idx_s    = tb_idx_r;
    tb_state_s  = tb_state_r;
    out_idx_s   = out_idx_r;
    nxt_idx_s   = out_idx_r + AW'(1);
    lifo_s      = lifo_r;
    out_valid_s = out_valid_r;
    out_bit_s   = out_bit_r;
    out_last_s  = out_last_r;
    case (state_r)
      FILL: begin
        out_valid_s = 1'b0;
        wr_cnt_s    = fill_cnt_s;
        if (accept_s && (wr_cnt_r == CNT_LAST)) begin
          state_s    = TRACE;
          len_s      = LEN_FULL;
          tb_idx_s   = IDX_LAST;
          tb_state_s = start_sel_s;
        end else if (bus.flush && (fill_cnt_s != {CW{1'b0}})) begin
          state_s    = TRACE;
          len_s      = fill_cnt_s;
          tb_idx_s   = AW'(fill_cnt_s - CW'(1));
          tb_state_s = start_sel_s;
        end else begin
          state_s = FILL;
        end
      end
      TRACE: begin
        lifo_s[tb_idx_r] = tb_state_r[0];
        tb_state_s       = SW'(prev_state(MAX_SW'(tb_state_r), d_s, SW));
        if (tb_idx_r == {AW{1'b0}}) begin
          // lifo[0] is being written now, so the first bit is taken directly.
          state_s     = EMIT;
          out_idx_s   = {AW{1'b0}};
          out_valid_s = 1'b1;
          out_bit_s   = tb_state_r[0];
          out_last_s  = (len_r == CW'(1));
        end else begin
          tb_idx_s = tb_idx_r - AW'(1);
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          if (out_last_r) begin
            state_s     = FILL;
            wr_cnt_s    = {CW{1'b0}};
            out_valid_s = 1'b0;
            out_bit_s   = 1'b0;
            out_last_s  = 1'b0;
          end else begin
            out_idx_s  = nxt_idx_s;
            out_bit_s  = lifo_r[nxt_idx_s];
            out_last_s = (CW'(nxt_idx_s) == (len_r - CW'(1)));
          end
        end else begin
          out_idx_s = out_idx_r;
        end
      end
      default: begin
        state_s     = FILL;
        wr_cnt_s    = {CW{1'b0}};
        out_valid_s = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= FILL;
      wr_cnt_r    <= {CW{1'b0}};
      len_r       <= {CW{1'b0}};
      tb_idx_r    <= {AW{1'b0}};
      tb_state_r  <= {SW{1'b0}};
      out_idx_r   <= {AW{1'b0}};
      lifo_r      <= {TB_LEN{1'b0}};
      out_valid_r <= 1'b0;
      out_bit_r   <= 1'b0;
      out_last_r  <= 1'b0;
      busy_r      <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      state_r     <= state_s;
      wr_cnt_r    <= wr_cnt_s;
      len_r       <= len_s;
      tb_idx_r    <= tb_idx_s;
      tb_state_r  <= tb_state_s;
      out_idx_r   <= out_idx_s;
      lifo_r      <= lifo_s;
      out_valid_r <= out_valid_s;
      out_bit_r   <= out_bit_s;
      out_last_r  <= out_last_s;
      busy_r      <= (state_s != FILL);
      in_ready_r  <= (state_s == FILL);
    end
  end

  assign bus.in_ready  = in_ready_r & ~reset;
  assign bus.out_valid = out_valid_r;
  assign bus.out_bit   = out_bit_r;
  assign bus.out_last  = out_last_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_viterbi_traceback.sv
// Self-checking bench for viterbi_traceback (SW=3, TB_LEN=4): table vectors, corner sequences, random windows.
module tb_viterbi_traceback;

  localparam int SW  = 3;
  localparam int NS  = 8;
  localparam int TBL = 4;
`ifdef VITERBI_TB_BEST_START_EN
  localparam bit BEST_EN = 1'b1;
`else
  localparam bit BEST_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  viterbi_traceback_if #(.SW(SW)) bus ();

  viterbi_traceback #(.SW(SW), .TB_LEN(TBL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [TBL-1:0][NS-1:0] dec;
    logic [TBL-1:0][SW-1:0] best;
    logic [2:0]             n;
    logic [1:0]             fmode;   // 0 none, 1 separate flush cycle, 2 flush with last accept
    logic [TBL-1:0]         exp_on;  // bit i = i-th emitted bit, start from best_state
    logic [TBL-1:0]         exp_off; // bit i = i-th emitted bit, start from state 0
  } vec_t;

  vec_t vecs[5];
  int   checks = 0;
  int   errors = 0;

  logic [NS-1:0] w_dec[TBL];
  logic [SW-1:0] w_best[TBL];
  int            w_n;
  int            w_fmode;
  logic          exp_bits[TBL];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: walk back from the start state using the survivor bits, record s[0] per step.
  task automatic model_window();
    int st, d;
    st = BEST_EN ? int'(w_best[w_n-1]) : 0;
    for (int i = w_n - 1; i >= 0; i--) begin
      exp_bits[i] = st[0];
      d  = int'((w_dec[i] >> st) & 8'h01);
      st = d * (NS / 2) + st / 2;
    end
  endtask

  task automatic send_window();
    for (int i = 0; i < w_n; i++) begin
      bus.in_valid   = 1'b1;
      bus.dec_vec    = w_dec[i];
      bus.best_state = w_best[i];
      bus.flush      = (w_fmode == 2) && (i == w_n - 1);
      @(posedge clk); #1;
    end
    bus.in_valid   = 1'b0;
    bus.flush      = 1'b0;
    bus.dec_vec    = NS'($urandom);
    bus.best_state = SW'($urandom);
    if (w_fmode == 1) begin
      bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0;
    end
  endtask

  task automatic collect(input string tag, input int stall_pct, input bit block_in, input int hold);
    int   cyc, got, first_v, held;
    bit   ir_ok, pstall;
    logic pbit, plast;
    cyc = 0; got = 0; first_v = -1; held = 0; ir_ok = 1'b1; pstall = 1'b0;
    pbit = 1'b0; plast = 1'b0;
    while (got < w_n && cyc < 200) begin
      if (block_in) begin
        bus.in_valid   = 1'b1;
        bus.dec_vec    = 8'hFF;
        bus.best_state = 3'd7;
      end
      if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) ir_ok = 1'b0;
      if (pstall) begin
        check($sformatf("%s stall_valid", tag), 32'(bus.out_valid), 32'd1);
        check($sformatf("%s stall_bit", tag), 32'(bus.out_bit), 32'(pbit));
        check($sformatf("%s stall_last", tag), 32'(bus.out_last), 32'(plast));
      end
      if (hold > 0 && got == 1 && held < hold && bus.out_valid === 1'b1) begin
        bus.out_ready = 1'b0;
        held++;
      end else begin
        bus.out_ready = ($urandom_range(99) >= stall_pct);
      end
      if (bus.out_valid === 1'b1 && first_v < 0) first_v = cyc;
      if (bus.out_valid === 1'b1 && bus.out_ready) begin
        check($sformatf("%s bit%0d", tag, got), 32'(bus.out_bit), 32'(exp_bits[got]));
        check($sformatf("%s last%0d", tag, got), 32'(bus.out_last), 32'(got == w_n - 1));
        got++;
      end
      pstall = (bus.out_valid === 1'b1) && !bus.out_ready;
      pbit   = bus.out_bit;
      plast  = bus.out_last;
      @(posedge clk); #1;
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check($sformatf("%s count", tag), 32'(got), 32'(w_n));
    check($sformatf("%s latency", tag), 32'(first_v), 32'(w_n));
    check($sformatf("%s blocked", tag), 32'(ir_ok), 32'd1);
    if (stall_pct == 0 && hold == 0)
      check($sformatf("%s busy_cycles", tag), 32'(cyc), 32'(2 * w_n));
    check($sformatf("%s in_ready_back", tag), 32'(bus.in_ready), 32'd1);
    check($sformatf("%s out_valid_low", tag), 32'(bus.out_valid), 32'd0);
    check($sformatf("%s busy_low", tag), 32'(bus.busy), 32'd0);
  endtask

  task automatic load_vec(input int v);
    w_n     = int'(vecs[v].n);
    w_fmode = int'(vecs[v].fmode);
    for (int i = 0; i < TBL; i++) begin
      w_dec[i]    = vecs[v].dec[i];
      w_best[i]   = vecs[v].best[i];
      exp_bits[i] = BEST_EN ? vecs[v].exp_on[i] : vecs[v].exp_off[i];
    end
  endtask

  initial begin
    vecs[0] = '{dec: {8'h08, 8'h00, 8'h00, 8'h00}, best: {3'd3, 3'd5, 3'd2, 3'd1},
                n: 3'd4, fmode: 2'd0, exp_on: 4'b1101, exp_off: 4'b0000};
    vecs[1] = '{dec: {8'h00, 8'h00, 8'h00, 8'h00}, best: {3'd0, 3'd0, 3'd2, 3'd2},
                n: 3'd2, fmode: 2'd1, exp_on: 4'b0001, exp_off: 4'b0000};
    vecs[2] = '{dec: {8'hFF, 8'hFF, 8'hFF, 8'hFF}, best: {3'd5, 3'd0, 3'd0, 3'd0},
                n: 3'd4, fmode: 2'd0, exp_on: 4'b1011, exp_off: 4'b0001};
    vecs[3] = '{dec: {8'h00, 8'h04, 8'h02, 8'h01}, best: {3'd0, 3'd6, 3'd0, 3'd0},
                n: 3'd3, fmode: 2'd2, exp_on: 4'b0011, exp_off: 4'b0000};
    vecs[4] = '{dec: {8'h00, 8'h00, 8'h00, 8'h01}, best: {3'd0, 3'd0, 3'd0, 3'd1},
                n: 3'd1, fmode: 2'd2, exp_on: 4'b0001, exp_off: 4'b0000};

    reset = 1'b1;
    bus.in_valid = 1'b0; bus.dec_vec = '0; bus.best_state = '0;
    bus.flush = 1'b0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", 32'(bus.in_ready), 32'd0);
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset out_bit", 32'(bus.out_bit), 32'd0);
    check("reset out_last", 32'(bus.out_last), 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;
    #1;
    check("release in_ready", 32'(bus.in_ready), 32'd1);

    // Flush of an empty window is ignored.
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("empty flush in_ready", 32'(bus.in_ready), 32'd1);
    check("empty flush busy", 32'(bus.busy), 32'd0);

    for (int v = 0; v < 5; v++) begin
      load_vec(v);
      check($sformatf("vec%0d start_ready", v), 32'(bus.in_ready), 32'd1);
      send_window();
      collect($sformatf("vec%0d", v), 0, 1'b0, 0);
    end

    // Backpressure for 5 cycles plus blocked input during EMIT, then a flush window.
    load_vec(0);
    send_window();
    collect("bp", 0, 1'b1, 5);
    load_vec(1);
    send_window();
    collect("after_block", 0, 1'b0, 0);

    // Reset in the second TRACE cycle, then a fresh all-zero window.
    for (int i = 0; i < TBL; i++) begin
      w_dec[i] = 8'hFF; w_best[i] = SW'($urandom);
    end
    w_n = TBL; w_fmode = 0;
    send_window();
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("midtrace reset in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("midtrace out_valid", 32'(bus.out_valid), 32'd0);
    check("midtrace in_ready", 32'(bus.in_ready), 32'd1);
    check("midtrace busy", 32'(bus.busy), 32'd0);
    for (int i = 0; i < TBL; i++) begin
      w_dec[i] = 8'h00; w_best[i] = 3'd0;
    end
    model_window();
    send_window();
    collect("post_reset", 0, 1'b0, 0);

    // Random windows against the reference model.
    for (int k = 0; k < 40; k++) begin
      w_n = $urandom_range(1, TBL);
      if (w_n == TBL) w_fmode = ($urandom_range(1) == 0) ? 0 : 2;
      else            w_fmode = $urandom_range(1, 2);
      for (int i = 0; i < TBL; i++) begin
        w_dec[i]  = NS'($urandom);
        w_best[i] = SW'($urandom);
      end
      model_window();
      send_window();
      collect($sformatf("rnd%0d", k), 30, ($urandom_range(3) == 0), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/viterbi_traceback.md
Name: viterbi_traceback

Overview:
- Survivor-memory and traceback stage of the Viterbi decoder.
- Sits directly downstream of the ACS array and the best-state decision unit.
- Each trellis step it stores the per-state survivor decision bits, plus the best (minimum-metric) state for that step.
- Once a window is full, or a flush is requested, it traces back through the stored window one column per cycle and emits the decoded bits in chronological order.

Parameters:
- SW, 3, state width in bits; number of states NS = 2**SW (derived localparam, default 8).
- TB_LEN, 16, traceback window length in trellis steps; legal range 2..64.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  dec_vec/best_state valid for this trellis step
- in_ready  out  1  block accepts a step; accept = in_valid & in_ready
- dec_vec  in  NS  survivor bit per state; bit s = MSB of the chosen predecessor of state s
- best_state  in  SW  minimum-metric state for this step, from the decision unit
- flush  in  1  force traceback of a partially filled window
- out_valid  out  1  out_bit valid
- out_ready  in  1  consumer accepts; transfer = out_valid & out_ready
- out_bit  out  1  decoded information bit
- out_last  out  1  marks the final bit of the current window
- busy  out  1  high in TRACE and EMIT

Behaviour:
- Trellis convention: next = {s[SW-2:0], u}.
  - Predecessor of s with survivor bit d is {d, s[SW-1:1]}.
  - Decoded bit at s is s[0].
- Reset (reset high at a clk edge):
  - state=FILL; wr_cnt=0; out_valid=0; out_bit=0; out_last=0; busy=0.
  - in_ready is forced 0 while reset is high and is 1 in the first cycle after release.
- FILL (in_ready=1):
  - On accept: mem[wr_cnt]=dec_vec; start_state=best_state; wr_cnt++.
  - If that accept fills column TB_LEN-1: len=TB_LEN, tb_idx=TB_LEN-1, next state=TRACE.
  - flush high with (wr_cnt + accept) > 0: len=wr_cnt+accept, tb_idx=len-1, next state=TRACE. A same-cycle accept is stored first and is included in len.
  - flush with an empty window is ignored.
- TRACE (in_ready=0, busy=1), one column per cycle:
  - d=mem[tb_idx][tb_state]; lifo[tb_idx]=tb_state[0]; tb_state={d, tb_state[SW-1:1]}; tb_idx--.
  - tb_state is initialised to start_state on entry.
  - After column 0 is processed, go to EMIT with out_idx=0.
- EMIT (in_ready=0, busy=1):
  - out_valid=1, out_bit=lifo[out_idx], out_last=(out_idx==len-1).
  - On transfer, out_idx++.
  - The transfer with out_last=1 returns to FILL, wr_cnt=0, out_valid=0 next cycle.
  - out_bit/out_last are held stable while out_ready=0.
- Latency: final accept at edge t → TRACE during cycles t+1..t+len → first out_valid at t+len+1.
- Throughput: one window per (len + len + stall) cycles. Upstream must honour in_ready; in_valid while in_ready=0 is ignored and the data is not stored.
- flush in TRACE/EMIT is ignored.
- Reset mid-TRACE/EMIT abandons the window; no partial output.
- Out-of-range best_state cannot occur; the full SW width is used.

Optional Feature:
- Macro: VITERBI_TB_BEST_START_EN.
- Defined: traceback starts from the latched best_state of the last accepted column.
- Undefined: traceback starts from state 0 (zero-terminated trellis). best_state is ignored, the port remains present, and the start_state register is not built.

Decomposition:
- Package viterbi_pkg holds:
  - default SW and TB_LEN constants;
  - enum tb_fsm_e {FILL, TRACE, EMIT};
  - function prev_state(state, d) returning {d, state[SW-1:1]}.
- One natural sub-module: viterbi_survivor_ram.
  - TB_LEN x NS storage.
  - One synchronous write port; one asynchronous column read port, needed for a single-cycle traceback step.
- FSM, LIFO and output logic stay in viterbi_traceback.

Test Plan (SW=3, TB_LEN=4 unless stated):
- Known path, macro on:
  - Stimulus: dec_vec = 8'h00, 8'h00, 8'h00, 8'h08 with best_state = 1, 2, 5, 3; out_ready=1.
  - Response: in_ready low for 8 cycles; out_bit sequence 1,0,1,1; out_last on the 4th; first out_valid 5 cycles after the final accept.
- Same stimulus, macro off:
  - Response: trace from state 0 with d=0 gives out_bit 0,0,0,0 (the col3 bit at state 3 is never reached).
- Flush:
  - Stimulus: accept 2 steps (dec_vec=8'h00, best_state=2), then flush=1 with no accept.
  - Response: exactly 2 outputs, 0 then 0, out_last on the 2nd; block then returns to in_ready=1.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles in EMIT.
  - Response: out_valid stays 1 and out_bit/out_last are unchanged; on release, bits continue in order with none lost or duplicated.
- Reset mid-TRACE:
  - Stimulus: assert reset in the 2nd TRACE cycle, then run a fresh all-zero window.
  - Response: out_valid=0 and in_ready=1 after release; the new window decodes 0,0,0,0 with no residue from the aborted window.
- Input blocking:
  - Stimulus: in_valid=1 with dec_vec=8'hFF during EMIT.
  - Response: data not stored; the next window's contents equal only the steps accepted after returning to FILL.
